seq_alu: RTL and testbench

//   Parametrised, handshaked successor of the single-cycle datapath ALU.
//   - Registered result for logic/shift/add ops.
//   - Adds OR, iterative MUL (low half) and signed DIV/REM.
//   - valid/ready on input and output, so stalls and multi-cycle ops sit cleanly in the pipelined core.

---
 rtl/seq_alu.sv | 191 +++++++++++++++++++
 tb/tb_seq_alu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/shift/add ops, iterative MUL and signed DIV/REM.
// One request in flight; the result is held in DONE until out_ready_i takes it.
module seq_alu #(
    parameter int WIDTH  = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             illegal_o
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_XOR = 4'b0001;
    localparam logic [3:0] OP_SLL = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_DIV = 4'b1000;
    localparam logic [3:0] OP_REM = 4'b1001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    // MUL: acc = partial product, opa = multiplicand, opb = multiplier.
    // DIV: acc = partial remainder, opa = |divisor|, opb = dividend shifting into quotient.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             illegal_q, illegal_d;

    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] single_res;
    logic             single_op;
    logic [WIDTH-1:0] mul_acc_nxt;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_nxt;
    logic [WIDTH-1:0] div_quo_nxt;
    logic [WIDTH-1:0] quo_res;
    logic [WIDTH-1:0] rem_res;

    assign shamt = src2_i[SW-1:0];

    always_comb begin
        single_res = '0;
        single_op  = 1'b1;
        case (op_i)
            OP_AND:  single_res = src1_i & src2_i;
            OP_XOR:  single_res = src1_i ^ src2_i;
            OP_OR:   single_res = src1_i | src2_i;
            OP_SLL:  single_res = src1_i << shamt;
            OP_SRA:  single_res = WIDTH'($signed(src1_i) >>> shamt);
            OP_ADD:  single_res = src1_i + src2_i;
            OP_SUB:  single_res = src1_i - src2_i;
            default: single_op  = 1'b0;
        endcase
    end

    // One iteration of shift-add and of restoring division, evaluated every BUSY cycle.
    always_comb begin
        mul_acc_nxt = acc_q + (opb_q[0] ? opa_q : '0);
        rem_sh      = {acc_q, opb_q[WIDTH-1]};
        div_sub     = rem_sh - {1'b0, opa_q};
        div_ge      = ~div_sub[WIDTH];
        div_rem_nxt = div_ge ? div_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        div_quo_nxt = {opb_q[WIDTH-2:0], div_ge};
        quo_res     = dz_q ? '1 : (neg_q ? -div_quo_nxt : div_quo_nxt);
        rem_res     = rem_neg_q ? -div_rem_nxt : div_rem_nxt;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        data_d    = data_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    op_d  = op_i;
                    cnt_d = '0;
                    acc_d = '0;
                    if (single_op) begin
                        data_d    = single_res;
                        illegal_d = 1'b0;
                        state_d   = DONE;
                    end else if (op_i == OP_MUL) begin
                        opa_d   = src1_i;
                        opb_d   = src2_i;
                        state_d = BUSY;
                    end else if (DIV_EN && (op_i == OP_DIV || op_i == OP_REM)) begin
                        // Magnitudes as unsigned; MIN maps onto 2^(WIDTH-1) correctly.
                        opa_d     = src2_i[WIDTH-1] ? -src2_i : src2_i;
                        opb_d     = src1_i[WIDTH-1] ? -src1_i : src1_i;
                        neg_d     = src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
                        rem_neg_d = src1_i[WIDTH-1];
                        dz_d      = (src2_i == '0);
                        state_d   = BUSY;
                    end else begin
                        data_d    = '0;
                        illegal_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc_nxt;
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end else begin
                    acc_d = div_rem_nxt;
                    opb_d = div_quo_nxt;
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    illegal_d = 1'b0;
                    if (op_q == OP_MUL)      data_d = mul_acc_nxt;
                    else if (op_q == OP_DIV) data_d = quo_res;
                    else                     data_d = rem_res;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            data_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            data_q    <= data_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign data_o      = data_q;
    assign zero_o      = (data_q == '0);
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table plus hand-written multi-cycle sequences.
// Latency is counted as the edge (relative to accept edge N) at which out_valid is first seen.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_a = 1'b0;
    logic        in_valid_b = 1'b0;
    logic [3:0]  op = 4'h0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        out_ready = 1'b1;

    logic        rdy_a, ov_a, zero_a, ill_a;
    logic        rdy_b, ov_b, zero_b, ill_b;
    logic [31:0] data_a, data_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32), .DIV_EN(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_a), .in_ready_o(rdy_a),
        .op_i(op), .src1_i(src1), .src2_i(src2), .out_valid_o(ov_a),
        .out_ready_i(out_ready), .data_o(data_a), .zero_o(zero_a), .illegal_o(ill_a)
    );

    seq_alu #(.WIDTH(32), .DIV_EN(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_b), .in_ready_o(rdy_b),
        .op_i(op), .src1_i(src1), .src2_i(src2), .out_valid_o(ov_b),
        .out_ready_i(out_ready), .data_o(data_b), .zero_o(zero_b), .illegal_o(ill_b)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_zero;
        logic        exp_ill;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns one negedge after the result was seen (consumed if out_ready=1).
    task automatic run_op(input bit sel_b, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] d, output logic z,
                          output logic il, output int lat);
        int guard = 0;
        while (!(sel_b ? rdy_b : rdy_a) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        op = o; src1 = a; src2 = b;
        if (sel_b) in_valid_b = 1'b1; else in_valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        lat = 1;
        while (!(sel_b ? ov_b : ov_a) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        d  = sel_b ? data_b : data_a;
        z  = sel_b ? zero_b : zero_a;
        il = sel_b ? ill_b : ill_a;
        @(negedge clk);
    endtask

    vec_t        vecs[$];
    logic [31:0] d;
    logic        z, il;
    int          lat;
    int          bad;

    initial begin
        vecs.push_back('{"add_ovf",  4'b0011, 32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1'b0, 1'b0, 1});
        vecs.push_back('{"sub_zero", 4'b0100, 32'd5,         32'd5,          32'h0,         1'b1, 1'b0, 1});
        vecs.push_back('{"and",      4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'hF000_F000, 1'b0, 1'b0, 1});
        vecs.push_back('{"xor",      4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'h0FF0_0FF0, 1'b0, 1'b0, 1});
        vecs.push_back('{"or",       4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'hFFF0_FFF0, 1'b0, 1'b0, 1});
        vecs.push_back('{"sra",      4'b0111, 32'h8000_0000, 32'h24,         32'hF800_0000, 1'b0, 1'b0, 1});
        vecs.push_back('{"sll",      4'b0010, 32'h1,         32'd31,         32'h8000_0000, 1'b0, 1'b0, 1});
        vecs.push_back('{"mul_neg",  4'b0101, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFEB, 1'b0, 1'b0, 33});
        vecs.push_back('{"mul_wrap", 4'b0101, 32'h0001_0000, 32'h0001_0000,  32'h0,         1'b1, 1'b0, 33});
        vecs.push_back('{"div_neg",  4'b1000, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b0, 1'b0, 33});
        vecs.push_back('{"rem_neg",  4'b1001, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b0, 1'b0, 33});
        vecs.push_back('{"div_mix",  4'b1000, 32'd100,       32'hFFFF_FFF9,  32'hFFFF_FFF2, 1'b0, 1'b0, 33});
        vecs.push_back('{"rem_mix",  4'b1001, 32'd100,       32'hFFFF_FFF9,  32'd2,         1'b0, 1'b0, 33});
        vecs.push_back('{"div_by0",  4'b1000, 32'd9,         32'd0,          32'hFFFF_FFFF, 1'b0, 1'b0, 33});
        vecs.push_back('{"rem_by0",  4'b1001, 32'd9,         32'd0,          32'd9,         1'b0, 1'b0, 33});
        vecs.push_back('{"divn_by0", 4'b1000, 32'hFFFF_FFF7, 32'd0,          32'hFFFF_FFFF, 1'b0, 1'b0, 33});
        vecs.push_back('{"div_ovf",  4'b1000, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 1'b0, 1'b0, 33});
        vecs.push_back('{"rem_ovf",  4'b1001, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         1'b1, 1'b0, 33});
        vecs.push_back('{"ill_c",    4'b1100, 32'd3,         32'd4,          32'h0,         1'b1, 1'b1, 1});
        vecs.push_back('{"ill_f",    4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0,         1'b1, 1'b1, 1});

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(rdy_a), 32'd1);
        chk("rst_valid", 32'(ov_a),  32'd0);
        chk("rst_data",  data_a,     32'h0);
        chk("rst_zero",  32'(zero_a), 32'd1);
        chk("rst_ill",   32'(ill_a),  32'd0);

        foreach (vecs[i]) begin
            run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, d, z, il, lat);
            chk({vecs[i].name, "_data"}, d, vecs[i].exp_data);
            chk({vecs[i].name, "_zero"}, 32'(z), 32'(vecs[i].exp_zero));
            chk({vecs[i].name, "_ill"},  32'(il), 32'(vecs[i].exp_ill));
            chk({vecs[i].name, "_lat"},  32'(lat), 32'(vecs[i].exp_lat));
        end

        // MUL with in_valid pulses of an ADD during BUSY: they must be ignored
        op = 4'b0101; src1 = 32'hFFFF_FFFD; src2 = 32'd7; in_valid_a = 1'b1;
        @(posedge clk);
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            op = 4'b0011; src1 = 32'd1; src2 = 32'd1;
            in_valid_a = i[0];
            if (rdy_a !== 1'b0 || ov_a !== 1'b0) bad++;
        end
        @(negedge clk);
        in_valid_a = 1'b0;
        chk("busy_ignored", 32'(bad), 32'd0);
        chk("busy_valid_n33", 32'(ov_a), 32'd1);
        chk("busy_mul_data", data_a, 32'hFFFF_FFEB);
        @(negedge clk);
        chk("busy_no_extra", 32'(ov_a), 32'd0);
        chk("busy_idle", 32'(rdy_a), 32'd1);

        // Backpressure: result held 10 cycles, taken on release, next op accepted right away
        out_ready = 1'b0;
        run_op(1'b0, 4'b0011, 32'd2, 32'd3, d, z, il, lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (ov_a !== 1'b1 || data_a !== 32'd5 || rdy_a !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("bp_held", 32'(bad), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_taken", 32'(ov_a), 32'd0);
        chk("bp_ready", 32'(rdy_a), 32'd1);
        run_op(1'b0, 4'b0100, 32'd10, 32'd3, d, z, il, lat);
        chk("bp_next_lat", 32'(lat), 32'd1);
        chk("bp_next_data", d, 32'd7);

        // Reset at BUSY step 10 of a DIV aborts it
        op = 4'b1000; src1 = 32'd100; src2 = 32'd7; in_valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_a = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 32'(rdy_a), 32'd1);
        chk("abort_valid", 32'(ov_a), 32'd0);
        chk("abort_data", data_a, 32'h0);
        chk("abort_zero", 32'(zero_a), 32'd1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ov_a !== 1'b0) bad++;
        end
        chk("abort_no_result", 32'(bad), 32'd0);

        // DIV_EN=0: DIV/REM illegal, MUL still iterative
        run_op(1'b1, 4'b1000, 32'd9, 32'd3, d, z, il, lat);
        chk("nodiv_div_ill", 32'(il), 32'd1);
        chk("nodiv_div_data", d, 32'h0);
        chk("nodiv_div_lat", 32'(lat), 32'd1);
        run_op(1'b1, 4'b1001, 32'd9, 32'd3, d, z, il, lat);
        chk("nodiv_rem_ill", 32'(il), 32'd1);
        run_op(1'b1, 4'b0101, 32'd6, 32'd7, d, z, il, lat);
        chk("nodiv_mul_data", d, 32'd42);
        chk("nodiv_mul_ill", 32'(il), 32'd0);
        chk("nodiv_mul_lat", 32'(lat), 32'd33);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end
endmodule
